// File: rtl/gnn_pkg.sv
// Shared defaults, FSM state encoding and a sizing helper for the GNN classification stage.
package gnn_pkg;

   localparam int SCORE_W         = 16;
   localparam int NUM_CLASSES_DEF = 3;
   localparam int NUM_NODES_DEF   = 6;

   typedef enum logic [1:0] {
      ARG_IDLE,
      ARG_READ,
      ARG_DRAIN,
      ARG_FINISH
   } argmax_state_e;

   // Index width that never collapses to zero bits.
   function automatic int clog2_min1(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/gnn_argmax_unit_if.sv
// Score-buffer read port: registered strobe/address out, row data back one cycle later.
interface gnn_argmax_unit_if
   import gnn_pkg::*;
#(
   parameter int NUM_NODES   = NUM_NODES_DEF,
   parameter int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int DATA_W      = SCORE_W
);

   localparam int ADDR_W = clog2_min1(NUM_NODES);

   logic                          rd_en;
   logic [ADDR_W-1:0]             rd_addr;
   logic [NUM_CLASSES*DATA_W-1:0] rd_data;

   modport master (
      output rd_en,
      output rd_addr,
      input  rd_data
   );

   modport slave (
      input  rd_en,
      input  rd_addr,
      output rd_data
   );

endinterface

// File: rtl/argmax_reduce.sv
// Combinational argmax over one packed score row; ties resolve to the lowest class index.
module argmax_reduce
   import gnn_pkg::*;
#(
   parameter  int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter  int DATA_W      = SCORE_W,
   parameter  int SIGNED      = 0,
   localparam int CLS_W       = clog2_min1(NUM_CLASSES)
) (
   input  logic [NUM_CLASSES*DATA_W-1:0] row,
   output logic [CLS_W-1:0]              idx,
   output logic [DATA_W-1:0]             max_val
);

   function automatic logic beats(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      if (SIGNED != 0) begin
         return $signed(a) > $signed(b);
      end
      return a > b;
   endfunction

   // A later class displaces the running winner only when strictly greater.
   always_comb begin
      idx     = '0;
      max_val = row[0 +: DATA_W];
      for (int k = 1; k < NUM_CLASSES; k++) begin
         if (beats(row[k*DATA_W +: DATA_W], max_val)) begin
            idx     = CLS_W'(k);
            max_val = row[k*DATA_W +: DATA_W];
         end
      end
   end

endmodule

// File: rtl/gnn_argmax_unit.sv
// Walks the score buffer once per accepted start, storing per-node argmax/max and a class histogram.
// Pass takes NUM_NODES+2 cycles after start; start is ignored while busy.
module gnn_argmax_unit
   import gnn_pkg::*;
#(
   parameter  int NUM_NODES   = NUM_NODES_DEF,
   parameter  int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter  int DATA_W      = SCORE_W,
   parameter  int SIGNED      = 0,
   localparam int CLS_W       = clog2_min1(NUM_CLASSES),
   localparam int ADDR_W      = clog2_min1(NUM_NODES),
   localparam int CNT_W       = $clog2(NUM_NODES + 1)
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         start,
   gnn_argmax_unit_if.master            rd_if,
   output logic [NUM_NODES*CLS_W-1:0]   class_out,
   output logic [NUM_NODES*DATA_W-1:0]  max_out,
   output logic [NUM_CLASSES*CNT_W-1:0] class_hist,
   output logic                         busy,
   output logic                         done,
   output logic                         result_valid
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_NODES - 1);

   argmax_state_e                state_q, state_d;
   logic                         rd_en_q, rd_en_d;
   logic [ADDR_W-1:0]            rd_addr_q, rd_addr_d;
   logic                         data_vld_q, data_vld_d;
   logic [ADDR_W-1:0]            wr_idx_q, wr_idx_d;
   logic [NUM_NODES*CLS_W-1:0]   class_q, class_d;
   logic [NUM_NODES*DATA_W-1:0]  max_q, max_d;
   logic [NUM_CLASSES*CNT_W-1:0] hist_q, hist_d;
   logic                         busy_q, busy_d;
   logic                         done_q, done_d;
   logic                         valid_q, valid_d;

   logic [CLS_W-1:0]             win_idx;
   logic [DATA_W-1:0]            win_val;

   argmax_reduce #(
      .NUM_CLASSES (NUM_CLASSES),
      .DATA_W      (DATA_W),
      .SIGNED      (SIGNED)
   ) u_reduce (
      .row     (rd_if.rd_data),
      .idx     (win_idx),
      .max_val (win_val)
   );

   always_comb begin
      state_d    = state_q;
      rd_en_d    = 1'b0;
      rd_addr_d  = rd_addr_q;
      data_vld_d = rd_en_q;
      wr_idx_d   = rd_addr_q;
      class_d    = class_q;
      max_d      = max_q;
      hist_d     = hist_q;
      valid_d    = valid_q;

      case (state_q)
         ARG_IDLE: begin
            if (start) begin
               state_d   = ARG_READ;
               rd_en_d   = 1'b1;
               rd_addr_d = '0;
               valid_d   = 1'b0;
               hist_d    = '0;
            end
         end
         ARG_READ: begin
            if (rd_addr_q == LAST_ADDR) begin
               state_d = ARG_DRAIN;
            end else begin
               rd_en_d   = 1'b1;
               rd_addr_d = rd_addr_q + ADDR_W'(1);
            end
         end
         ARG_DRAIN: begin
            state_d = ARG_FINISH;
            valid_d = 1'b1;
         end
         ARG_FINISH: begin
            state_d = ARG_IDLE;
         end
         default: begin
            state_d = ARG_IDLE;
         end
      endcase

      // Returning row lands one cycle behind its address; rd_data is ignored otherwise.
      if (data_vld_q) begin
         class_d[int'(wr_idx_q)*CLS_W +: CLS_W]  = win_idx;
         max_d[int'(wr_idx_q)*DATA_W +: DATA_W]  = win_val;
         hist_d[int'(win_idx)*CNT_W +: CNT_W]    = hist_q[int'(win_idx)*CNT_W +: CNT_W] + CNT_W'(1);
      end

      busy_d = (state_d != ARG_IDLE);
      done_d = (state_d == ARG_FINISH);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= ARG_IDLE;
         rd_en_q    <= 1'b0;
         rd_addr_q  <= '0;
         data_vld_q <= 1'b0;
         wr_idx_q   <= '0;
         class_q    <= '0;
         max_q      <= '0;
         hist_q     <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         valid_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rd_en_q    <= rd_en_d;
         rd_addr_q  <= rd_addr_d;
         data_vld_q <= data_vld_d;
         wr_idx_q   <= wr_idx_d;
         class_q    <= class_d;
         max_q      <= max_d;
         hist_q     <= hist_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         valid_q    <= valid_d;
      end
   end

   assign rd_if.rd_en   = rd_en_q;
   assign rd_if.rd_addr = rd_addr_q;
   assign class_out     = class_q;
   assign max_out       = max_q;
   assign class_hist    = hist_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign result_valid  = valid_q;

endmodule

// File: tb/tb_gnn_argmax_unit.sv
// Directed bench for gnn_argmax_unit: default, signed and wide configurations with 1-cycle memory models.
module tb_gnn_argmax_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset;
   logic start0, start1, start2;
   int   vectors     = 0;
   int   miscompares = 0;

   gnn_argmax_unit_if #(.NUM_NODES(6), .NUM_CLASSES(3), .DATA_W(16)) rd0 ();
   gnn_argmax_unit_if #(.NUM_NODES(2), .NUM_CLASSES(3), .DATA_W(16)) rd1 ();
   gnn_argmax_unit_if #(.NUM_NODES(8), .NUM_CLASSES(5), .DATA_W(8))  rd2 ();

   logic [17:0] cls0;  logic [95:0] max0;  logic [8:0]  hist0;  logic busy0, done0, rv0;
   logic [3:0]  cls1;  logic [31:0] max1;  logic [5:0]  hist1;  logic busy1, done1, rv1;
   logic [23:0] cls2;  logic [63:0] max2;  logic [19:0] hist2;  logic busy2, done2, rv2;

   gnn_argmax_unit #(.NUM_NODES(6), .NUM_CLASSES(3), .DATA_W(16), .SIGNED(0)) u0 (
      .clk(clk), .reset(reset), .start(start0), .rd_if(rd0),
      .class_out(cls0), .max_out(max0), .class_hist(hist0),
      .busy(busy0), .done(done0), .result_valid(rv0));

   gnn_argmax_unit #(.NUM_NODES(2), .NUM_CLASSES(3), .DATA_W(16), .SIGNED(1)) u1 (
      .clk(clk), .reset(reset), .start(start1), .rd_if(rd1),
      .class_out(cls1), .max_out(max1), .class_hist(hist1),
      .busy(busy1), .done(done1), .result_valid(rv1));

   gnn_argmax_unit #(.NUM_NODES(8), .NUM_CLASSES(5), .DATA_W(8), .SIGNED(0)) u2 (
      .clk(clk), .reset(reset), .start(start2), .rd_if(rd2),
      .class_out(cls2), .max_out(max2), .class_hist(hist2),
      .busy(busy2), .done(done2), .result_valid(rv2));

   // Score buffers: row valid one cycle after rd_en, garbage otherwise.
   logic [47:0] mem0 [8];
   logic [47:0] mem1 [2];
   logic [39:0] mem2 [8];

   always @(posedge clk) begin
      rd0.rd_data <= rd0.rd_en ? mem0[rd0.rd_addr] : {$urandom(), 16'($urandom())};
      rd1.rd_data <= rd1.rd_en ? mem1[rd1.rd_addr] : {$urandom(), 16'($urandom())};
      rd2.rd_data <= rd2.rd_en ? mem2[rd2.rd_addr] : {$urandom(), 8'($urandom())};
   end

   int ec0 [6];
   int em0 [6];
   int eh0 [3];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero0(input string tag);
      check({tag, " rd_en"},   rd0.rd_en,   0);
      check({tag, " rd_addr"}, rd0.rd_addr, 0);
      check({tag, " class"},   cls0,        0);
      check({tag, " max"},     max0,        0);
      check({tag, " hist"},    hist0,       0);
      check({tag, " busy"},    busy0,       0);
      check({tag, " done"},    done0,       0);
      check({tag, " rv"},      rv0,         0);
   endtask

   task automatic check_res0(input string tag);
      for (int n = 0; n < 6; n++) begin
         check($sformatf("%s class[%0d]", tag, n), cls0[n*2 +: 2],  ec0[n]);
         check($sformatf("%s max[%0d]", tag, n),   max0[n*16 +: 16], em0[n]);
      end
      for (int k = 0; k < 3; k++) begin
         check($sformatf("%s hist[%0d]", tag, k), hist0[k*3 +: 3], eh0[k]);
      end
   endtask

   // Start must be high on entry; cycle c is observed after the c-th edge counting the accept edge.
   task automatic watch0(input int pulse_at);
      for (int c = 1; c <= 10; c++) begin
         tick();
         if (c == 1) start0 = 1'b0;
         check($sformatf("busy c%0d", c),    busy0,       (c <= 8));
         check($sformatf("done c%0d", c),    done0,       (c == 8));
         check($sformatf("rd_en c%0d", c),   rd0.rd_en,   (c <= 6));
         check($sformatf("rd_addr c%0d", c), rd0.rd_addr, (c <= 6) ? c - 1 : 5);
         check($sformatf("rv c%0d", c),      rv0,         (c >= 8));
         if (c == pulse_at) start0 = 1'b1;
         else if (c == pulse_at + 1) start0 = 1'b0;
      end
   endtask

   initial begin
      logic [39:0] row;
      logic [7:0]  v;
      logic [7:0]  bv;
      int          best;
      int          got;
      int          hsum;
      int          ec2 [8];
      int          em2 [8];
      int          eh2 [5];

      reset  = 1'b1;
      start0 = 1'b0;
      start1 = 1'b0;
      start2 = 1'b0;
      mem0[0] = {16'd1, 16'd2, 16'd5};
      mem0[1] = {16'd3, 16'd9, 16'd1};
      mem0[2] = {16'd7, 16'd0, 16'd0};
      mem0[3] = {16'd4, 16'd4, 16'd4};
      mem0[4] = {16'd8, 16'd8, 16'd2};
      mem0[5] = {16'd0, 16'd1, 16'd3};
      mem0[6] = '0;
      mem0[7] = '0;
      mem1[0] = {16'h8000, 16'h0000, 16'hFFFF};
      mem1[1] = {16'h7FFF, 16'h8000, 16'h7FFF};

      repeat (2) tick();
      check_zero0("reset");
      check("reset u1 busy", busy1, 0);
      check("reset u2 hist", hist2, 0);
      reset = 1'b0;
      tick();

      // Pass A: main rows, timing checked cycle by cycle.
      ec0 = '{0, 1, 2, 0, 1, 0};
      em0 = '{5, 9, 7, 4, 8, 3};
      eh0 = '{3, 2, 1};
      start0 = 1'b1;
      watch0(0);
      check_res0("passA");

      // Pass B: extra start pulse during READ must be ignored.
      start0 = 1'b1;
      watch0(3);
      check_res0("passB");

      // Reset in cycle 4 of a pass, then a clean pass on altered rows.
      mem0[0] = {16'h8000, 16'h0000, 16'hFFFF};
      mem0[3] = {16'd6, 16'd2, 16'd1};
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      #1;
      check_zero0("midreset");
      tick();
      reset = 1'b0;
      tick();
      ec0 = '{0, 1, 2, 2, 1, 0};
      em0 = '{16'hFFFF, 9, 7, 6, 8, 3};
      eh0 = '{2, 2, 2};
      start0 = 1'b1;
      watch0(0);
      check_res0("postreset");

      // Start held high: back-to-back passes.
      start0 = 1'b1;
      for (int c = 1; c <= 20; c++) begin
         tick();
         check($sformatf("b2b done c%0d", c), done0, (c == 8) || (c == 17));
         check($sformatf("b2b rv c%0d", c),   rv0,   ((c >= 8) && (c <= 9)) || ((c >= 17) && (c <= 18)));
      end
      start0 = 1'b0;
      for (int i = 0; i < 15 && busy0; i++) tick();
      check("b2b idle", busy0, 0);
      check("b2b rv end", rv0, 1);
      check_res0("b2b");

      // Signed configuration: -1 vs 0 vs -32768, and a tie at the top.
      start1 = 1'b1;
      tick();
      start1 = 1'b0;
      got = 0;
      for (int i = 0; i < 10 && got == 0; i++) begin
         tick();
         if (done1) got = 1;
      end
      check("u1 done seen", got, 1);
      check("u1 class[0]", cls1[1:0],   1);
      check("u1 max[0]",   max1[15:0],  16'h0000);
      check("u1 class[1]", cls1[3:2],   0);
      check("u1 max[1]",   max1[31:16], 16'h7FFF);
      check("u1 hist",     hist1,       {2'd0, 2'd1, 2'd1});
      tick();
      check("u1 busy end", busy1, 0);
      check("u1 rv end",   rv1,   1);

      // Wide configuration: coarse random scores so ties and the 255 ceiling occur often.
      for (int k = 0; k < 5; k++) eh2[k] = 0;
      for (int n = 0; n < 8; n++) begin
         row  = '0;
         for (int k = 0; k < 5; k++) begin
            v = 8'($urandom_range(0, 3) * 85);
            row[k*8 +: 8] = v;
         end
         best = 0;
         bv   = row[7:0];
         for (int k = 1; k < 5; k++) begin
            if (row[k*8 +: 8] > bv) begin
               best = k;
               bv   = row[k*8 +: 8];
            end
         end
         mem2[n] = row;
         ec2[n]  = best;
         em2[n]  = bv;
         eh2[best]++;
      end
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      got = 0;
      for (int i = 0; i < 20 && got == 0; i++) begin
         tick();
         if (done2) got = 1;
      end
      check("u2 done seen", got, 1);
      for (int n = 0; n < 8; n++) begin
         check($sformatf("u2 class[%0d]", n), cls2[n*3 +: 3], ec2[n]);
         check($sformatf("u2 max[%0d]", n),   max2[n*8 +: 8], em2[n]);
      end
      hsum = 0;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("u2 hist[%0d]", k), hist2[k*4 +: 4], eh2[k]);
         hsum += int'(hist2[k*4 +: 4]);
      end
      check("u2 hist sum", hsum, 8);
      tick();
      check("u2 busy end", busy2, 0);
      check("u2 rv end",   rv2,   1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/gnn_argmax_unit.md
Name: gnn_argmax_unit

Overview:
Parametrised classification stage at the GNN output. After the final aggregation/linear layer has written one score row per node into the score buffer, this block walks that buffer. For each node it selects the highest-scoring class and records the result. It also keeps a per-class node histogram and signals completion to the top-level controller with a start/busy/done handshake.

Parameters:
NUM_NODES, 6, number of score rows (nodes) to classify; >= 2
NUM_CLASSES, 3, scores per row; >= 2
DATA_W, 16, width of one score
SIGNED, 0, 1 = scores are two's complement, 0 = unsigned
Derived (localparam, not overridable): CLS_W = max(1, clog2(NUM_CLASSES)); ADDR_W = max(1, clog2(NUM_NODES)); CNT_W = clog2(NUM_NODES+1)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high; clears all state and outputs
start  in  1  request a classification pass; sampled only in IDLE
rd_en  out  1  score-buffer read strobe
rd_addr  out  ADDR_W  node index being read
rd_data  in  NUM_CLASSES*DATA_W  score row; class k at bits [k*DATA_W +: DATA_W]; valid exactly 1 cycle after rd_en
class_out  out  NUM_NODES*CLS_W  argmax per node; node n at [n*CLS_W +: CLS_W]
max_out  out  NUM_NODES*DATA_W  winning score per node, same packing
class_hist  out  NUM_CLASSES*CNT_W  number of nodes assigned to each class in the last pass
busy  out  1  high from the cycle after start is accepted until done
done  out  1  single-cycle pulse when the pass completes
result_valid  out  1  high from done until the next accepted start or reset

Behaviour:
- Reset values: rd_en=0, rd_addr=0, class_out=0, max_out=0, class_hist=0, busy=0, done=0, result_valid=0; FSM state=IDLE.
- FSM states: IDLE, READ, DRAIN, FINISH.
- IDLE: start=1 -> READ. On the same edge: result_valid<=0, class_hist<=0, rd_addr<=0. class_out/max_out keep their old values until overwritten.
- READ: rd_en=1, and rd_addr increments every cycle. When rd_addr==NUM_NODES-1 -> DRAIN; rd_addr holds.
- DRAIN: rd_en=0 for one cycle, during which the last row returns -> FINISH.
- FINISH: done=1 and result_valid<=1 for one cycle -> IDLE.
- rd_en and rd_addr are registered. A pipelined copy of the address (wr_idx) and of rd_en (data_vld) travel with the 1-cycle read latency.
- On each data_vld cycle:
  - class_out[wr_idx] <= argmax(rd_data); max_out[wr_idx] <= winning score.
  - class_hist[argmax] increments.
- Argmax compare: signed or unsigned per SIGNED. Ties go to the lowest class index: a later class wins only if it is strictly greater.
- Timing: start sampled at edge 0; rd_en high cycles 1..NUM_NODES; results written at edges 2..NUM_NODES+1; done high in cycle NUM_NODES+2; busy high in cycles 1..NUM_NODES+2.
- start while not in IDLE is ignored, with no queueing. start held high continuously re-triggers a new pass on the cycle after FINISH.
- rd_data is don't-care when data_vld=0 and must not affect any state.
- Reset asserted mid-pass aborts immediately to reset values. No partial results survive.
- Histogram counters cannot overflow: CNT_W covers NUM_NODES.

Decomposition:
- Shared package gnn_pkg: SCORE_W default, NUM_CLASSES/NUM_NODES defaults, the argmax FSM state enum.
- Sub-module argmax_reduce: combinational, parameters NUM_CLASSES, DATA_W, SIGNED.
  - Input: packed row. Outputs: idx (CLS_W) and max value.
  - Implemented as a linear strict-greater chain from class 0 upward.
- gnn_argmax_unit holds the FSM, address/valid pipeline, result registers and histogram.

Test Plan:
- Default params, rows {5,2,1},{1,9,3},{0,0,7},{4,4,4},{2,8,8},{3,1,0}, 1-cycle-latency memory model -> class_out={0,1,2,0,1,0}, max_out={5,9,7,4,8,3}, class_hist={3,2,1}; done high exactly in cycle 8 after start.
- SIGNED=1, row {16'hFFFF,16'h0000,16'h8000} -> class 1, max 0. Same row with SIGNED=0 -> class 0, max 16'hFFFF.
- start pulsed again during READ -> ignored: exactly one done pulse, rd_addr sequence 0..5 once, busy continuous.
- Reset asserted at cycle 4 of a pass -> all outputs 0 next cycle. A subsequent start runs a full pass with correct results and hist not carrying over.
- start held high for 20 cycles -> back-to-back passes: done in cycles 8 and 17, result_valid drops on each re-accept.
- NUM_NODES=8, NUM_CLASSES=5, DATA_W=8 with random rows vs reference model -> all class_out, max_out and class_hist match; sum of hist == 8.
